// File: rtl/reg_scoreboard.sv
// Purpose: per-register pending-write counters; holds decode on RAW and WAW-saturation hazards.
// Latency: id_stall and id_fire are combinational; counters and err update on the next clk edge.
// Backpressure: id_stall ignores id_allowin; id_fire needs id_valid && id_allowin && !id_stall.
module reg_scoreboard #(
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       id_valid,
    input  logic       id_allowin,
    input  logic       id_rs1_used,
    input  logic [4:0] id_raddr1,
    input  logic       id_rs2_used,
    input  logic [4:0] id_raddr2,
    input  logic       id_dest_we,
    input  logic [4:0] id_dest,
    output logic       id_stall,
    output logic       id_fire,
    input  logic       wb_we,
    input  logic [4:0] wb_waddr,
    input  logic       cancel_valid,
    input  logic [4:0] cancel_dest,
    output logic       busy_any,
    output logic       err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt      [32];
    logic [CNT_W-1:0] cnt_nxt  [32];
    logic [CNT_W:0]   sum_w    [32];
    logic [CNT_W:0]   dec_w    [32];
    logic [31:0]      wb_hit;
    logic [31:0]      cn_hit;
    logic [31:0]      inc_vec;
    logic [31:0]      uflow;
    logic             haz1;
    logic             haz2;
    logic             sat;

    // Decode which registers are retired by WB or cancel this cycle; r0 is never tracked.
    always_comb begin
        wb_hit = '0;
        cn_hit = '0;
        for (int r = 1; r < 32; r++) begin
            wb_hit[r] = wb_we && (wb_waddr == 5'(r));
            cn_hit[r] = cancel_valid && (cancel_dest == 5'(r));
        end
    end

    // Source hazards and destination-counter saturation; a cancel never clears a source hazard.
    always_comb begin
        haz1 = id_rs1_used && (id_raddr1 != 5'd0) && (cnt[id_raddr1] != '0);
        haz2 = id_rs2_used && (id_raddr2 != 5'd0) && (cnt[id_raddr2] != '0);
        if (WB_BYPASS) begin
            if ((cnt[id_raddr1] == CNT_ONE) && wb_hit[id_raddr1]) haz1 = 1'b0;
            if ((cnt[id_raddr2] == CNT_ONE) && wb_hit[id_raddr2]) haz2 = 1'b0;
        end
        sat = id_dest_we && (id_dest != 5'd0) && (cnt[id_dest] == CNT_MAX) &&
              !wb_hit[id_dest] && !cn_hit[id_dest];
        id_stall = id_valid && (haz1 || haz2 || sat);
        id_fire  = id_valid && id_allowin && !id_stall;
    end

    // Issue increments the destination counter of the instruction that fires.
    always_comb begin
        inc_vec = '0;
        for (int r = 1; r < 32; r++) begin
            inc_vec[r] = id_fire && id_dest_we && (id_dest == 5'(r));
        end
    end

    // Net next count per register; more retirements than pending writes clamps to zero.
    always_comb begin
        uflow = '0;
        for (int r = 0; r < 32; r++) begin
            sum_w[r]   = {1'b0, cnt[r]} + (CNT_W+1)'(inc_vec[r]);
            dec_w[r]   = (CNT_W+1)'(wb_hit[r]) + (CNT_W+1)'(cn_hit[r]);
            cnt_nxt[r] = '0;
            if (dec_w[r] > sum_w[r]) begin
                uflow[r] = 1'b1;
            end else begin
                cnt_nxt[r] = CNT_W'(sum_w[r] - dec_w[r]);
            end
        end
    end

    // Counter and sticky error state; reset discards all pending writes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
            err <= 1'b0;
        end else begin
            for (int r = 0; r < 32; r++) cnt[r] <= cnt_nxt[r];
            if (|uflow) err <= 1'b1;
        end
    end

    // Any register with writes outstanding, from registered counts only.
    always_comb begin
        busy_any = 1'b0;
        for (int r = 0; r < 32; r++) begin
            if (cnt[r] != '0) busy_any = 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Purpose: randomized and directed checks of reg_scoreboard, both bypass settings, against a count model.
// Latency: combinational outputs checked mid-cycle; registered outputs checked after the edge.
// Backpressure: id_allowin is driven randomly and must never influence id_stall.
module tb_reg_scoreboard;

    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       resetn, id_valid, id_allowin, id_rs1_used, id_rs2_used, id_dest_we;
    logic [4:0] id_raddr1, id_raddr2, id_dest, wb_waddr, cancel_dest;
    logic       wb_we, cancel_valid;
    logic       stall0, fire0, busy0, err0;
    logic       stall1, fire1, busy1, err1;

    int  n_checks = 0;
    int  n_pass   = 0;
    int  mcnt [2][32];
    bit  merr [2];
    bit  o_stall [2];
    bit  o_fire  [2];

    always #5 clk = ~clk;

    reg_scoreboard #(.CNT_W(CNT_W), .WB_BYPASS(1'b0)) u_sb0 (
        .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_allowin(id_allowin),
        .id_rs1_used(id_rs1_used), .id_raddr1(id_raddr1), .id_rs2_used(id_rs2_used),
        .id_raddr2(id_raddr2), .id_dest_we(id_dest_we), .id_dest(id_dest),
        .id_stall(stall0), .id_fire(fire0), .wb_we(wb_we), .wb_waddr(wb_waddr),
        .cancel_valid(cancel_valid), .cancel_dest(cancel_dest), .busy_any(busy0), .err(err0)
    );

    reg_scoreboard #(.CNT_W(CNT_W), .WB_BYPASS(1'b1)) u_sb1 (
        .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_allowin(id_allowin),
        .id_rs1_used(id_rs1_used), .id_raddr1(id_raddr1), .id_rs2_used(id_rs2_used),
        .id_raddr2(id_raddr2), .id_dest_we(id_dest_we), .id_dest(id_dest),
        .id_stall(stall1), .id_fire(fire1), .wb_we(wb_we), .wb_waddr(wb_waddr),
        .cancel_valid(cancel_valid), .cancel_dest(cancel_dest), .busy_any(busy1), .err(err1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Retirements of register r this cycle, counting WB and cancel separately.
    function automatic int m_dec(input int r);
        int d = 0;
        if (r != 0 && wb_we && wb_waddr == 5'(r)) d++;
        if (r != 0 && cancel_valid && cancel_dest == 5'(r)) d++;
        return d;
    endfunction

    function automatic bit m_src_haz(input int b, input bit used, input logic [4:0] s);
        int c = mcnt[b][s];
        if (!used || s == 0 || c == 0) return 1'b0;
        if (b == 1 && c == 1 && wb_we && wb_waddr == s) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall(input int b);
        bit sat;
        sat = id_dest_we && id_dest != 0 && mcnt[b][id_dest] == MAXC && m_dec(int'(id_dest)) == 0;
        return id_valid && (m_src_haz(b, id_rs1_used, id_raddr1) ||
                            m_src_haz(b, id_rs2_used, id_raddr2) || sat);
    endfunction

    function automatic bit m_busy(input int b);
        for (int r = 0; r < 32; r++) if (mcnt[b][r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    // One cycle: drive after negedge, check mid-cycle, advance the model at posedge.
    task automatic step(input bit rn, input bit v, input bit al,
                        input bit u1, input logic [4:0] a1, input bit u2, input logic [4:0] a2,
                        input bit dwe, input logic [4:0] d,
                        input bit wwe, input logic [4:0] wa, input bit cv, input logic [4:0] cd);
        bit es [2];
        bit ef [2];
        @(negedge clk);
        resetn = rn; id_valid = v; id_allowin = al;
        id_rs1_used = u1; id_raddr1 = a1; id_rs2_used = u2; id_raddr2 = a2;
        id_dest_we = dwe; id_dest = d; wb_we = wwe; wb_waddr = wa;
        cancel_valid = cv; cancel_dest = cd;
        #2;
        for (int b = 0; b < 2; b++) begin
            es[b] = m_stall(b);
            ef[b] = v && al && !es[b];
        end
        o_stall[0] = stall0; o_fire[0] = fire0;
        o_stall[1] = stall1; o_fire[1] = fire1;
        check("stall_b0", 32'(stall0), 32'(es[0]));
        check("fire_b0",  32'(fire0),  32'(ef[0]));
        check("stall_b1", 32'(stall1), 32'(es[1]));
        check("fire_b1",  32'(fire1),  32'(ef[1]));
        check("busy_b0",  32'(busy0),  32'(m_busy(0)));
        check("busy_b1",  32'(busy1),  32'(m_busy(1)));
        check("err_b0",   32'(err0),   32'(merr[0]));
        check("err_b1",   32'(err1),   32'(merr[1]));
        @(posedge clk);
        for (int b = 0; b < 2; b++) begin
            for (int r = 1; r < 32; r++) begin
                int inc = (ef[b] && dwe && d == 5'(r)) ? 1 : 0;
                int dec = m_dec(r);
                if (dec > mcnt[b][r] + inc) begin
                    mcnt[b][r] = 0;
                    merr[b] = 1'b1;
                end else begin
                    mcnt[b][r] = mcnt[b][r] + inc - dec;
                end
            end
            if (!rn) begin
                for (int r = 0; r < 32; r++) mcnt[b][r] = 0;
                merr[b] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle(input bit rn);
        step(rn, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    endtask

    task automatic issue(input logic [4:0] d, input bit wwe, input logic [4:0] wa);
        step(1, 1, 1, 0, 5'd0, 0, 5'd0, 1, d, wwe, wa, 0, 5'd0);
    endtask

    task automatic retire(input bit wwe, input logic [4:0] wa, input bit cv, input logic [4:0] cd);
        step(1, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, wwe, wa, cv, cd);
    endtask

    initial begin
        for (int b = 0; b < 2; b++) begin
            merr[b] = 1'b0;
            for (int r = 0; r < 32; r++) mcnt[b][r] = 0;
        end
        resetn = 0; id_valid = 0; id_allowin = 0; id_rs1_used = 0; id_raddr1 = 0;
        id_rs2_used = 0; id_raddr2 = 0; id_dest_we = 0; id_dest = 0;
        wb_we = 0; wb_waddr = 0; cancel_valid = 0; cancel_dest = 0;

        // Reset state, then a plain reader issues.
        idle(0); idle(0);
        check("rst_busy", 32'(busy0 | busy1), 32'd0);
        check("rst_err",  32'(err0 | err1), 32'd0);
        step(1, 1, 1, 1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        check("rst_fire", 32'({o_fire[1], o_fire[0]}), 32'd3);

        // RAW on r5 with and without WB bypass.
        issue(5'd5, 0, 5'd0);
        step(1, 1, 1, 1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        check("raw_stall", 32'({o_stall[1], o_stall[0]}), 32'd3);
        step(1, 1, 1, 1, 5'd5, 0, 5'd0, 0, 5'd0, 1, 5'd5, 0, 5'd0);
        check("raw_wb_b0", 32'(o_stall[0]), 32'd1);
        check("raw_wb_b1", 32'(o_stall[1]), 32'd0);
        step(1, 1, 1, 1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        check("raw_after", 32'(o_stall[0]), 32'd0);

        // Same-cycle issue and retire of r7.
        issue(5'd7, 0, 5'd0);
        issue(5'd7, 1, 5'd7);
        check("inc_dec_busy", 32'(busy0), 32'd1);
        retire(1, 5'd7, 0, 5'd0);
        check("inc_dec_idle", 32'(busy0), 32'd0);

        // Saturation on r3, relieved by a same-cycle WB.
        issue(5'd3, 0, 5'd0); issue(5'd3, 0, 5'd0); issue(5'd3, 0, 5'd0);
        issue(5'd3, 0, 5'd0);
        check("sat_stall", 32'({o_stall[1], o_stall[0]}), 32'd3);
        issue(5'd3, 1, 5'd3);
        check("sat_wb_fire", 32'({o_fire[1], o_fire[0]}), 32'd3);
        issue(5'd3, 0, 5'd0);
        check("sat_still", 32'(o_stall[0]), 32'd1);
        retire(1, 5'd3, 0, 5'd0); retire(1, 5'd3, 0, 5'd0); retire(1, 5'd3, 0, 5'd0);

        // Cancel plus WB on r9, then underflow by cancel.
        issue(5'd9, 0, 5'd0); issue(5'd9, 0, 5'd0);
        retire(1, 5'd9, 1, 5'd9);
        check("cw_busy", 32'(busy0), 32'd0);
        check("cw_err", 32'(err0), 32'd0);
        retire(0, 5'd0, 1, 5'd9);
        check("uf_err", 32'({err1, err0}), 32'd3);
        idle(1); idle(1);
        check("uf_sticky", 32'({err1, err0}), 32'd3);

        // r0 never tracked.
        idle(0);
        check("rst2_err", 32'(err0), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 1, 1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 5'd0);
            check("r0_stall", 32'(o_stall[0]), 32'd0);
        end
        check("r0_busy", 32'(busy0), 32'd0);
        check("r0_err", 32'(err0), 32'd0);

        // Randomized traffic on a small register set, retirements biased to pending registers.
        for (int i = 0; i < 3000; i++) begin
            bit          rn  = ($urandom_range(0, 199) != 0);
            bit          wwe = ($urandom_range(0, 2) == 0);
            bit          cv  = ($urandom_range(0, 9) == 0);
            logic [4:0]  wa  = 5'($urandom_range(0, 7));
            logic [4:0]  cd  = 5'($urandom_range(0, 7));
            for (int k = 0; k < 4 && mcnt[0][wa] == 0; k++) wa = 5'($urandom_range(0, 7));
            for (int k = 0; k < 4 && mcnt[0][cd] == 0; k++) cd = 5'($urandom_range(0, 7));
            step(rn, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)),
                 wwe, wa, cv, cd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
